serial_flag_unit: RTL and testbench
===================================

// Module: serial_flag_unit
// PURPOSE
//  Multi-cycle comparator that produces the branch flags (zero, carry, overflow, sign).
//  It computes A - B as A + ~B + 1, DIGIT bits per cycle, LSB first.
//  It drives the branch control unit's flag inputs for area-reduced cores.
//  Valid/ready handshake on both sides; a synchronous flush aborts the operation on redirect.
// PARAMETERS
//  XLEN   32  operand width; must be a multiple of DIGIT
//  DIGIT  4   bits processed per RUN cycle; N = XLEN/DIGIT RUN cycles per operation
// PORTS
//  clk             in   1     single clock, rising edge
//  rst             in   1     asynchronous, active-high reset
//  in_valid        in   1     operands a, b presented
//  in_ready        out  1     unit can accept; 1 only in IDLE
//  a               in   XLEN  rs1 operand
//  b               in   XLEN  rs2 operand
//  flush           in   1     synchronous abort; squashes the in-flight or pending result
//  out_valid       out  1     flags and diff valid
//  out_ready       in   1     consumer takes the result
//  diff            out  XLEN  A - B (mod 2^XLEN)
//  zeroSignal      out  1     diff == 0
//  carrySignal     out  1     carry-out of A + ~B + 1 (1 = no borrow, A >= B unsigned)
//  overflowSignal  out  1     signed overflow of A - B
//  signSignal      out  1     diff[XLEN-1]
// BEHAVIOUR
//  - Reset (async): state = IDLE, in_ready = 1, out_valid = 0.
//    diff, all flags, the counter and the carry register clear to 0.
//  - FSM:
//    - IDLE: on in_valid & in_ready, latch a, b; carry_reg = 1; zero_acc = 0; cnt = 0; go to RUN.
//    - RUN, each cycle, with s = a_sh[DIGIT-1:0] + ~b_sh[DIGIT-1:0] + carry_reg:
//      - shift s[DIGIT-1:0] into diff from the MSB side;
//      - zero_acc |= |s[DIGIT-1:0]; carry_reg = s[DIGIT];
//      - shift a_sh and b_sh right by DIGIT; cnt++.
//    - RUN, on cnt == N-1, also:
//      - overflowSignal = carry into bit XLEN-1 XOR carry out of bit XLEN-1;
//      - carrySignal = final carry; signSignal = final MSB; zeroSignal = ~zero_acc;
//      - go to DONE.
//    - DONE: out_valid = 1. diff and flags are held stable while out_ready = 0.
//      out_valid & out_ready -> IDLE.
//  - Latency: out_valid rises exactly N cycles after the accepting edge (N = 8 by default).
//  - in_ready = (state == IDLE); no new operand is accepted in RUN or DONE.
//  - Flush: RUN or DONE -> IDLE next edge. out_valid deasserts at that edge.
//    - flush wins over out_ready.
//    - flush in IDLE has priority over in_valid: no accept occurs that cycle.
//  - Flags update only at the RUN->DONE transition.
//    After DONE they keep their last values (do-not-care) until the next completion.
//  - Carry convention: carrySignal = 1 when a >= b unsigned.
//    a == b gives zero=1, carry=1, ovf=0, sign=0.
//  - Reset asserted mid-RUN or mid-DONE: immediate return to reset values; the result is lost.
// CONFIGURATION
//  CMP_EQ_FAST_EN
//   - defined: on accept, if a == b the unit goes directly to DONE, skipping RUN.
//     - out_valid rises 1 cycle after the accepting edge.
//     - diff = 0, zero=1, carry=1, ovf=0, sign=0.
//     - a != b takes the normal N-cycle path.
//   - undefined: every operation takes N cycles; no XLEN-wide equality comparator is built.
// TESTING (XLEN=32, DIGIT=4)
//  1. a=5, b=5 -> out_valid 8 cycles after accept; diff=0, Z=1, C=1, V=0, S=0.
//  2. a=0x80000000, b=1 -> diff=0x7FFFFFFF, Z=0, C=1, V=1, S=0.
//  3. a=1, b=2 -> diff=0xFFFFFFFF, Z=0, C=0, V=0, S=1. in_ready=0 during RUN/DONE.
//  4. a=3, b=7; out_ready held 0 for 5 cycles after out_valid.
//     -> diff/flags stable; in_ready=0; IDLE one edge after out_ready=1.
//  5. flush on the 3rd RUN cycle -> out_valid never rises; in_ready=1 next cycle.
//     Then reset mid-RUN -> all outputs 0 immediately.
//  6. CMP_EQ_FAST_EN, a=b=0x1234 -> out_valid 1 cycle after accept with Z=1, C=1.
//     a=0x1234, b=0x1235 -> 8 cycles; C=0, S=1.

Source files
------------

// File: rtl/serial_flag_unit.sv
// Digit-serial subtractor producing branch flags (zero, carry, overflow, sign) from A - B.
// Optional feature: define CMP_EQ_FAST_EN to retire equal operands without the serial pass.
module serial_flag_unit #(
    parameter int XLEN  = 32,
    parameter int DIGIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] diff,
    output logic            zeroSignal,
    output logic            carrySignal,
    output logic            overflowSignal,
    output logic            signSignal
);

    localparam int N  = XLEN / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state;
    stateT            stateNext;

    logic [XLEN-1:0]  aSh;
    logic [XLEN-1:0]  bSh;
    logic             carryReg;
    logic             zeroAcc;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             lastDigit;
    logic             finishRun;
    logic [DIGIT:0]   digitSum;
    logic             carryIntoMsb;

`ifdef CMP_EQ_FAST_EN
    logic             eqFast;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // A flush seen in IDLE blocks the accept in the same cycle.
    assign accept    = in_valid && (state == IDLE) && !flush;
    assign lastDigit = (cnt == CW'(N - 1));

`ifdef CMP_EQ_FAST_EN
    assign finishRun = lastDigit || eqFast;
`else
    assign finishRun = lastDigit;
`endif

    // One digit of A + ~B + carry; the extra top bit is the digit carry-out.
    assign digitSum = {1'b0, aSh[DIGIT-1:0]}
                    + {1'b0, ~bSh[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carryReg};

    // Recover the carry into the sum MSB from the MSB operand bits and sum bit.
    assign carryIntoMsb = aSh[DIGIT-1] ^ ~bSh[DIGIT-1] ^ digitSum[DIGIT-1];

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    stateNext = IDLE;
                end else if (finishRun) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aSh            <= '0;
            bSh            <= '0;
            carryReg       <= 1'b0;
            zeroAcc        <= 1'b0;
            cnt            <= '0;
            diff           <= '0;
            zeroSignal     <= 1'b0;
            carrySignal    <= 1'b0;
            overflowSignal <= 1'b0;
            signSignal     <= 1'b0;
`ifdef CMP_EQ_FAST_EN
            eqFast         <= 1'b0;
`endif
        end else begin
            if (accept) begin
                aSh      <= a;
                bSh      <= b;
                carryReg <= 1'b1;
                zeroAcc  <= 1'b0;
                cnt      <= '0;
`ifdef CMP_EQ_FAST_EN
                eqFast   <= (a == b);
`endif
            end else if (state == RUN && !flush) begin
`ifdef CMP_EQ_FAST_EN
                if (eqFast) begin
                    diff           <= '0;
                    zeroSignal     <= 1'b1;
                    carrySignal    <= 1'b1;
                    overflowSignal <= 1'b0;
                    signSignal     <= 1'b0;
                    eqFast         <= 1'b0;
                end else begin
`endif
                    diff     <= {digitSum[DIGIT-1:0], diff[XLEN-1:DIGIT]};
                    zeroAcc  <= zeroAcc | (|digitSum[DIGIT-1:0]);
                    carryReg <= digitSum[DIGIT];
                    aSh      <= aSh >> DIGIT;
                    bSh      <= bSh >> DIGIT;
                    cnt      <= cnt + CW'(1);
                    if (lastDigit) begin
                        zeroSignal     <= ~(zeroAcc | (|digitSum[DIGIT-1:0]));
                        carrySignal    <= digitSum[DIGIT];
                        overflowSignal <= carryIntoMsb ^ digitSum[DIGIT];
                        signSignal     <= digitSum[DIGIT-1];
                    end
`ifdef CMP_EQ_FAST_EN
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_flag_unit.sv
// Randomized self-checking bench for serial_flag_unit against an arithmetic reference model.
module tb_serial_flag_unit;

    localparam int XLEN  = 32;
    localparam int DIGIT = 4;
    localparam int N     = XLEN / DIGIT;
    localparam int BUDGET = 60;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] diff;
    logic            zeroSignal;
    logic            carrySignal;
    logic            overflowSignal;
    logic            signSignal;

    int tests    = 0;
    int failures = 0;

    serial_flag_unit #(.XLEN(XLEN), .DIGIT(DIGIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .diff           (diff),
        .zeroSignal     (zeroSignal),
        .carrySignal    (carrySignal),
        .overflowSignal (overflowSignal),
        .signSignal     (signSignal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    // {diff, Z, C, V, S} straight from the arithmetic definition of A - B.
    function automatic logic [XLEN+3:0] refModel(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        logic [XLEN-1:0] d;
        logic            z, c, v, s;
        d = x - y;
        z = (d == '0);
        c = (x >= y);
        v = (x[XLEN-1] != y[XLEN-1]) && (d[XLEN-1] != x[XLEN-1]);
        s = d[XLEN-1];
        return {d, z, c, v, s};
    endfunction

    function automatic int expLatency(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
`ifdef CMP_EQ_FAST_EN
        return (x == y) ? 1 : N;
`else
        if (x == y) return N;
        return N;
`endif
    endfunction

    function automatic logic [XLEN+3:0] observed();
        return {diff, zeroSignal, carrySignal, overflowSignal, signSignal};
    endfunction

    // Presents one operand pair, waits (bounded) for out_valid; returns latency in cycles
    // after the accepting edge (-1 on timeout) and how often in_ready was seen high while busy.
    task automatic issue(input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                         output int lat, output int readyHigh);
        int guard;
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        guard     = 0;
        readyHigh = 0;
        while (!in_ready && guard < BUDGET) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 0;
        while (!out_valid && lat < BUDGET) begin
            if (in_ready) readyHigh++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        tests++;
        if (observed() !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, required 0", observed());
        end
    endtask

    task automatic test_directed();
        logic [XLEN-1:0] va [3];
        logic [XLEN-1:0] vb [3];
        logic [XLEN+3:0] exp;
        logic [XLEN+3:0] got;
        int lat, rh;
        va[0] = 32'd5;          vb[0] = 32'd5;
        va[1] = 32'h8000_0000;  vb[1] = 32'd1;
        va[2] = 32'd1;          vb[2] = 32'd2;
        for (int i = 0; i < 3; i++) begin
            issue(va[i], vb[i], lat, rh);
            exp = refModel(va[i], vb[i]);
            got = observed();
            tests++;
            if (lat != expLatency(va[i], vb[i])) begin
                failures++;
                $display("FAIL directed%0d_latency: got %0d, required %0d", i, lat, expLatency(va[i], vb[i]));
            end
            tests++;
            if (got !== exp) begin
                failures++;
                $display("FAIL directed%0d_result: got %h, required %h", i, got, exp);
            end
            tests++;
            if (rh != 0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL directed%0d_in_ready_busy: high %0d times (now %b), required 0", i, rh, in_ready);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [XLEN+3:0] exp;
        int lat, rh, bad;
        issue(32'd3, 32'd7, lat, rh);
        exp = refModel(32'd3, 32'd7);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (observed() !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
            @(negedge clk);
        end
        tests++;
        if (lat != N || bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold: latency %0d unstable %0d, required %0d and 0", lat, bad, N);
        end
        release_result();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int seen;
        // flush during the third RUN cycle
        in_valid = 1'b1;
        a        = 32'h0000_1234;
        b        = 32'h0000_0042;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_run_ready: in_ready=%b, required 1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < N + 2; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        tests++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_run_no_valid: out_valid seen %0d cycles, required 0", seen);
        end
        // flush in DONE beats out_ready
        issue(32'd9, 32'd4, seen, seen);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        // flush in IDLE blocks an accept
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        tests++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle_blocks_accept: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        in_valid = 1'b1;
        a        = 32'hFFFF_0000;
        b        = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (observed() !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_run: outputs %h out_valid=%b in_ready=%b, required 0/0/1",
                     observed(), out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [XLEN-1:0] x, y;
        logic [XLEN-1:0] edges [6];
        logic [XLEN+3:0] exp;
        int lat, rh, mode, errs, delay;
        edges[0] = 32'h0000_0000; edges[1] = 32'hFFFF_FFFF; edges[2] = 32'h8000_0000;
        edges[3] = 32'h7FFF_FFFF; edges[4] = 32'h0000_0001; edges[5] = 32'h8000_0001;
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            mode = $urandom_range(0, 3);
            x = $urandom;
            y = $urandom;
            if (mode == 1) y = x;
            if (mode == 2) y = x + (($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF);
            if (mode == 3) begin
                x = edges[$urandom_range(0, 5)];
                y = edges[$urandom_range(0, 5)];
            end
            issue(x, y, lat, rh);
            exp = refModel(x, y);
            if (lat != expLatency(x, y) || observed() !== exp || rh != 0) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random_op a=%h b=%h: got lat %0d res %h, required lat %0d res %h",
                             x, y, lat, observed(), expLatency(x, y), exp);
            end
            delay = $urandom_range(0, 3);
            for (int d = 0; d < delay; d++) @(negedge clk);
            release_result();
        end
        tests++;
        if (errs != 0) begin
            failures++;
            $display("FAIL random_summary: %0d bad operations, required 0", errs);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] x, y;
        int lat, rh, errs;
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            y = (i == 2) ? x : $urandom;
            issue(x, y, lat, rh);
            tests++;
            if (lat != expLatency(x, y) || observed() !== refModel(x, y)) begin
                failures++;
                $display("FAIL back_to_back%0d: got lat %0d res %h, required lat %0d res %h",
                         i, lat, observed(), expLatency(x, y), refModel(x, y));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        test_reset();
        apply_reset();
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
